systolic_input_skew: RTL
========================

SYSTOLIC_INPUT_SKEW -- requirements
Module: systolic_input_skew

Interface
REQ-001 SHALL have parameter N, default 2, meaning number of array rows (output lanes), N>=1.
REQ-002 SHALL have parameter K, default 2, meaning number of matrix columns streamed per row, K>=1.
REQ-003 SHALL have parameter DATA_W, default 32, meaning element width in bits.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port wr_en  input  1  buffer write strobe.
REQ-007 SHALL have port wr_row  input  max(1,$clog2(N))  row index of the write.
REQ-008 SHALL have port wr_col  input  max(1,$clog2(K))  column index of the write.
REQ-009 SHALL have port wr_data  input  DATA_W  element written to A[wr_row][wr_col].
REQ-010 SHALL have port start  input  1  request to stream the buffered tile.
REQ-011 SHALL have port busy  output  1  high while streaming.
REQ-012 SHALL have port done  output  1  one-cycle pulse after the final step.
REQ-013 SHALL have port out_data  output  N*DATA_W  lane i at bits [i*DATA_W +: DATA_W].
REQ-014 SHALL have port out_valid  output  N  bit i qualifies lane i.

Function
REQ-015 SHALL hold an N x K element buffer A, unsigned and opaque (no arithmetic on data).
REQ-016 SHALL implement states IDLE, STREAM, DONE, held in registers.
REQ-017 IDLE: start=1 at a clock edge SHALL move to STREAM with step counter t=0; otherwise stay in IDLE.
REQ-018 STREAM: t SHALL increment each cycle; at t=K+N-2 the next state SHALL be DONE, giving exactly K+N-1 STREAM cycles.
REQ-019 DONE SHALL last exactly one cycle, then return to IDLE.
REQ-020 busy SHALL be 1 exactly in STREAM; done SHALL be 1 exactly in DONE.
REQ-021 In STREAM at step t, lane i SHALL output A[i][t-i] with out_valid[i]=1 when 0<=t-i<K; otherwise lane i SHALL output 0 with out_valid[i]=0.
REQ-022 Outside STREAM, out_data SHALL be 0 and out_valid SHALL be 0.
REQ-023 Outputs SHALL be a function of registered state, t and A only, with no combinational path from any input.
REQ-024 start SHALL be ignored in STREAM and DONE. There is no queuing, and a start held high from DONE SHALL be accepted in the following IDLE cycle.
REQ-025 A write SHALL commit at the clock edge when wr_en=1 in IDLE or DONE; writes in STREAM SHALL be ignored so the buffer is stable during a stream.
REQ-026 A write with wr_row>=N or wr_col>=K SHALL be ignored.
REQ-027 When wr_en and start are both accepted on the same edge in IDLE, the written element SHALL appear in the stream that starts.
REQ-028 The buffer SHALL retain its contents across streams, so a repeated start re-streams the same tile.
REQ-029 N=1 or K=1 SHALL be legal: the stream length is K+N-1 and the skew rule of REQ-021 is unchanged.

Reset
REQ-030 While rst=1, the block SHALL immediately (asynchronously) force state IDLE, t=0, all A elements 0, busy=0, done=0, out_data=0, out_valid=0.
REQ-031 Assertion of rst during STREAM SHALL abort the stream with no done pulse; after release the block SHALL wait for a new start.
REQ-032 The first clock edge after rst deasserts SHALL be able to accept a write or start.

Verification (N=2, K=2, DATA_W=32 unless noted)
REQ-033 Basic skew: write A=[[1,2],[3,4]], then pulse start. Required cycles:
- step0: lanes (1,0), valid 01b.
- step1: lanes (2,3), valid 11b.
- step2: lanes (0,4), valid 10b.
- next cycle: done=1, outputs 0.
- following cycle: IDLE.
REQ-034 Busy protection: during step1 of REQ-033, drive start=1 and write A[0][0]=9. The stream SHALL be unchanged and finish in 3 steps with a single done pulse. A rerun SHALL still stream 1 at step0.
REQ-035 Same-edge write/start: in IDLE, write A[1][0]=7 on the same edge as start. Step1 lane1 SHALL equal 7.
REQ-036 Reset mid-stream: assert rst during step1. Outputs SHALL be 0 immediately, done SHALL never pulse, and a subsequent start SHALL stream all-zero data with valid pattern 01b, 11b, 10b.
REQ-037 Parametric: with N=4, K=3, A[i][j]=10*i+j:
- stream length 6 cycles.
- step3: lanes (0,12,21,30), valid 1110b.
- out-of-range write wr_col=3 SHALL have no effect.
REQ-038 Back-to-back: hold start=1 continuously. Streams SHALL repeat with exactly one IDLE cycle between DONE and the next STREAM.

Source files
------------

// File: rtl/systolic_input_skew.sv
// systolic_input_skew: buffers an N x K tile and streams it row-skewed into a systolic array.
// Lane i lags lane i-1 by one cycle, so a stream lasts K+N-1 cycles followed by a one-cycle done pulse.
module systolic_input_skew #(
  parameter int N = 2,
  parameter int K = 2,
  parameter int DATA_W = 32,
  localparam int RW = N > 1 ? $clog2(N) : 1,
  localparam int CW = K > 1 ? $clog2(K) : 1,
  localparam int TW = K + N > 2 ? $clog2(K + N - 1) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [RW-1:0]     wr_row,
  input  logic [CW-1:0]     wr_col,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [N*DATA_W-1:0] out_data,
  output logic [N-1:0]      out_valid
);
  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;
  state_t r_state, w_next;
  logic [TW-1:0] r_t;
  logic [DATA_W-1:0] r_a [N][K];
  logic w_last, w_wr, w_stream;
  assign w_stream = r_state == S_STREAM;
  assign w_last = r_t == TW'(K + N - 2);
  // The buffer is frozen while streaming; out-of-range coordinates are dropped.
  assign w_wr = wr_en && !w_stream && 32'(wr_row) < N && 32'(wr_col) < K;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_t <= '0;
    end else begin
      r_state <= w_next;
      r_t <= w_stream && !w_last ? r_t + 1'b1 : '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < K; j++)
          r_a[i][j] <= '0;
    end else if (w_wr) begin
      r_a[wr_row][wr_col] <= wr_data;
    end
  end
  always_comb
    w_next = r_state == S_IDLE ? (start ? S_STREAM : S_IDLE) :
             w_stream ? (w_last ? S_DONE : S_STREAM) : S_IDLE;
  // Lane i carries column t-i of its row; everything else is zero.
  always_comb begin
    busy = w_stream;
    done = r_state == S_DONE;
    out_data = '0;
    out_valid = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < K; j++)
        if (w_stream && 32'(r_t) == 32'(i + j)) begin
          out_data[i*DATA_W +: DATA_W] = r_a[i][j];
          out_valid[i] = 1'b1;
        end
  end
endmodule
